// File: rtl/user_io_pkg.sv
// Shared definitions for the user I/O controller: register offsets inside the
// user-I/O window and the bit positions used in STATUS and CTRL.
package user_io_pkg;

    localparam logic [4:0] ADDR_STATUS   = 5'h00;
    localparam logic [4:0] ADDR_BTN_DATA = 5'h04;
    localparam logic [4:0] ADDR_SWITCH   = 5'h08;
    localparam logic [4:0] ADDR_LED      = 5'h0C;
    localparam logic [4:0] ADDR_CYCLES   = 5'h10;
    localparam logic [4:0] ADDR_CTRL     = 5'h14;

    localparam int STATUS_EMPTY    = 0;
    localparam int STATUS_FULL     = 1;
    localparam int STATUS_OVERFLOW = 2;

    localparam int CTRL_CLR_CYCLES   = 0;
    localparam int CTRL_CLR_OVERFLOW = 1;
    localparam int CTRL_FLUSH        = 2;

endpackage

// File: rtl/user_io_fifo.sv
// Button-event FIFO: pointer-plus-wrap-bit full/empty, flush beats push/pop,
// and a pop on a full FIFO makes room for a push in the same cycle.
module user_io_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic             dropped
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty && !flush;
    assign do_push  = push && !flush && (!full || do_pop);
    assign dropped  = push && !flush && full && !do_pop;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/user_io_ctrl.sv
// Memory-mapped user I/O block: button-event queue, switch synchronizer,
// LED register, free-running cycle counter and a registered read port.
module user_io_ctrl
    import user_io_pkg::*;
#(
    parameter int BTN_WIDTH  = 3,
    parameter int SW_WIDTH   = 2,
    parameter int LED_WIDTH  = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BTN_WIDTH-1:0] clean_buttons,
    input  logic [SW_WIDTH-1:0]  switches,
    output logic [LED_WIDTH-1:0] leds,
    input  logic [4:0]           io_addr,
    input  logic                 io_re,
    input  logic                 io_we,
    input  logic [31:0]          io_wdata,
    output logic [31:0]          io_rdata
);
    logic [BTN_WIDTH-1:0] btn_prev;
    logic [BTN_WIDTH-1:0] rise;
    logic [BTN_WIDTH-1:0] head;
    logic [SW_WIDTH-1:0]  sw_meta;
    logic [SW_WIDTH-1:0]  sw_sync;
    logic [31:0]          cycles;
    logic [31:0]          rd_next;
    logic                 overflow;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 dropped;
    logic                 pop;
    logic                 flush;
    logic                 ctrl_we;
    logic                 unused_wdata;

    assign rise         = clean_buttons & ~btn_prev;
    assign ctrl_we      = io_we && (io_addr == ADDR_CTRL);
    assign flush        = ctrl_we && io_wdata[CTRL_FLUSH];
    assign pop          = io_re && (io_addr == ADDR_BTN_DATA);
    assign unused_wdata = &{1'b0, io_wdata};

    user_io_fifo #(
        .WIDTH (BTN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (|rise),
        .pop       (pop),
        .flush     (flush),
        .push_data (rise),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .dropped   (dropped)
    );

    // Loaded during reset too, so buttons held through reset raise no event.
    always_ff @(posedge clk) begin
        btn_prev <= clean_buttons;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            leds     <= '0;
            cycles   <= '0;
            overflow <= 1'b0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            if (io_we && (io_addr == ADDR_LED)) leds <= io_wdata[LED_WIDTH-1:0];
            cycles <= (ctrl_we && io_wdata[CTRL_CLR_CYCLES]) ? '0 : cycles + 32'd1;
            // A drop in the same cycle as a clear still leaves overflow set.
            if (ctrl_we && io_wdata[CTRL_CLR_OVERFLOW]) overflow <= 1'b0;
            if (dropped) overflow <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns rd_next and no latch is inferred.
        rd_next = '0;
        case (io_addr)
            ADDR_STATUS: begin
                rd_next[STATUS_EMPTY]    = fifo_empty;
                rd_next[STATUS_FULL]     = fifo_full;
                rd_next[STATUS_OVERFLOW] = overflow;
            end
            ADDR_BTN_DATA: rd_next = 32'(head);
            ADDR_SWITCH:   rd_next = 32'(sw_sync);
            ADDR_LED:      rd_next = 32'(leds);
            ADDR_CYCLES:   rd_next = cycles;
            default:       rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            io_rdata <= '0;
        end else if (io_re) begin
            io_rdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_user_io_ctrl.sv
// Scoreboard bench for user_io_ctrl: a queue-based reference model predicts
// io_rdata and leds for every cycle; a monitor compares after each edge.
module tb_user_io_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  clean_buttons;
    logic [1:0]  switches;
    logic [5:0]  leds;
    logic [4:0]  io_addr;
    logic        io_re;
    logic        io_we;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    always #5 clk = ~clk;

    user_io_ctrl #(
        .BTN_WIDTH  (3),
        .SW_WIDTH   (2),
        .LED_WIDTH  (6),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clean_buttons (clean_buttons),
        .switches      (switches),
        .leds          (leds),
        .io_addr       (io_addr),
        .io_re         (io_re),
        .io_we         (io_we),
        .io_wdata      (io_wdata),
        .io_rdata      (io_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [5:0]  leds;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    logic [2:0]  ev_q[$];
    logic [1:0]  sw_hist[$];
    logic        m_ovf;
    logic [5:0]  m_leds;
    logic [31:0] m_cycles;
    logic [31:0] m_rdata;
    logic [2:0]  m_prev;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
        end
    endtask

    function automatic logic [31:0] read_value(input logic [4:0] addr);
        case (addr)
            5'h00: return {29'd0, m_ovf, ev_q.size() == DEPTH, ev_q.size() == 0};
            5'h04: return (ev_q.size() == 0) ? 32'd0 : 32'(ev_q[0]);
            5'h08: return 32'(sw_hist[1]);
            5'h0C: return 32'(m_leds);
            5'h10: return m_cycles;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic [2:0] btn, input logic re, input logic we,
                              input logic [4:0] addr, input logic [31:0] wd, input logic [1:0] sw);
        logic [2:0] rise;
        bit         ctrl;
        if (!r) begin
            ev_q.delete();
            sw_hist.delete();
            sw_hist.push_back(2'b00);
            sw_hist.push_back(2'b00);
            m_ovf    = 1'b0;
            m_leds   = '0;
            m_cycles = '0;
            m_rdata  = '0;
            m_prev   = btn;
            return;
        end
        if (re) m_rdata = read_value(addr);
        rise   = btn & ~m_prev;
        m_prev = btn;
        ctrl   = we && (addr == 5'h14);
        if (ctrl && wd[1]) m_ovf = 1'b0;
        if (ctrl && wd[2]) begin
            ev_q.delete();
        end else begin
            if (re && addr == 5'h04 && ev_q.size() > 0) void'(ev_q.pop_front());
            if (rise != 0) begin
                if (ev_q.size() < DEPTH) ev_q.push_back(rise);
                else m_ovf = 1'b1;
            end
        end
        if (we && addr == 5'h0C) m_leds = wd[5:0];
        m_cycles = (ctrl && wd[0]) ? 32'd0 : m_cycles + 32'd1;
        sw_hist.push_front(sw);
        void'(sw_hist.pop_back());
    endtask

    // One clock of stimulus, applied on the falling edge; expectation queued for the monitor.
    task automatic cyc(input logic r, input logic [2:0] btn, input logic re, input logic we,
                       input logic [4:0] addr, input logic [31:0] wd, input string tag);
        exp_t e;
        rst           = r;
        clean_buttons = btn;
        io_re         = re;
        io_we         = we;
        io_addr       = addr;
        io_wdata      = wd;
        model_edge(r, btn, re, we, addr, wd, switches);
        e.rdata = m_rdata;
        e.leds  = m_leds;
        e.tag   = tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [2:0] btn);
        for (int i = 0; i < n; i++) cyc(1'b1, btn, 1'b0, 1'b0, 5'h00, 32'd0, "idle");
    endtask

    task automatic rd(input logic [4:0] addr, input string tag);
        cyc(1'b1, 3'b000, 1'b1, 1'b0, addr, 32'd0, tag);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data, input string tag);
        cyc(1'b1, 3'b000, 1'b0, 1'b1, addr, data, tag);
    endtask

    task automatic press(input logic [2:0] mask);
        cyc(1'b1, mask, 1'b0, 1'b0, 5'h00, 32'd0, "press");
        cyc(1'b1, 3'b000, 1'b0, 1'b0, 5'h00, 32'd0, "release");
    endtask

    // Monitor: after each rising edge, compare outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, " rdata"}, io_rdata, e.rdata);
                check({e.tag, " leds"}, 32'(leds), 32'(e.leds));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [2:0]  masks[9];
        logic [2:0]  btn;
        logic        re;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;

        masks[0] = 3'd1; masks[1] = 3'd2; masks[2] = 3'd4;
        masks[3] = 3'd3; masks[4] = 3'd5; masks[5] = 3'd6;
        masks[6] = 3'd7; masks[7] = 3'd1; masks[8] = 3'd2;

        rst = 1'b0; clean_buttons = 3'b010; switches = 2'b00;
        io_addr = '0; io_re = 1'b0; io_we = 1'b0; io_wdata = '0;
        @(negedge clk);

        // Reset with button 1 held through release
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'b010, 1'b1, 1'b0, 5'h04, 32'd0, "reset");
        idle(2, 3'b010);
        cyc(1'b1, 3'b010, 1'b1, 1'b0, 5'h00, 32'd0, "post-reset status");
        cyc(1'b1, 3'b010, 1'b1, 1'b0, 5'h0C, 32'd0, "post-reset led");
        cyc(1'b1, 3'b010, 1'b1, 1'b0, 5'h10, 32'd0, "post-reset cycles");
        cyc(1'b1, 3'b010, 1'b1, 1'b0, 5'h10, 32'd0, "post-reset cycles again");
        idle(1, 3'b000);

        // Single and simultaneous presses
        press(3'b001);
        press(3'b110);
        rd(5'h00, "status two events");
        rd(5'h04, "pop first");
        rd(5'h04, "pop second");
        rd(5'h04, "pop empty");
        rd(5'h00, "status drained");
        rd(5'h1C, "unmapped read");

        // Overflow: nine presses into an eight-entry queue
        for (int i = 0; i < 9; i++) press(masks[i]);
        rd(5'h00, "status full+overflow");
        for (int i = 0; i < 8; i++) rd(5'h04, "overflow drain");
        wr(5'h14, 32'h2, "clear overflow");
        rd(5'h00, "status after clear");

        // Pop coincident with a press on a full queue
        for (int i = 0; i < 8; i++) press(masks[i]);
        cyc(1'b1, 3'b101, 1'b1, 1'b0, 5'h04, 32'd0, "pop+push on full");
        rd(5'h00, "status full no overflow");
        for (int i = 0; i < 9; i++) rd(5'h04, "drain after pop+push");

        // LED and switch paths
        wr(5'h0C, 32'hFFFF_FFEA, "led write");
        rd(5'h0C, "led readback");
        switches = 2'b11;
        idle(3, 3'b000);
        rd(5'h08, "switch sync");

        // CYCLES clear, flush with three queued events
        wr(5'h14, 32'h1, "clear cycles");
        rd(5'h10, "cycles after clear");
        press(3'b001); press(3'b010); press(3'b100);
        cyc(1'b1, 3'b011, 1'b0, 1'b1, 5'h14, 32'h4, "flush with push");
        rd(5'h00, "status after flush");
        rd(5'h04, "pop after flush");

        // Reset mid-operation
        press(3'b100);
        wr(5'h0C, 32'h15, "led before reset");
        cyc(1'b0, 3'b001, 1'b1, 1'b1, 5'h0C, 32'h3F, "mid reset");
        cyc(1'b1, 3'b001, 1'b1, 1'b0, 5'h00, 32'd0, "status after mid reset");
        rd(5'h0C, "led after mid reset");

        // Randomized traffic
        btn = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) btn = 3'($urandom);
            if ($urandom_range(0, 15) == 0) switches = 2'($urandom);
            re = ($urandom_range(0, 1) == 0);
            we = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2: addr = 5'h04;
                3, 4:    addr = 5'h00;
                default: addr = 5'($urandom_range(0, 7) * 4);
            endcase
            wd = $urandom;
            if (we && addr == 5'h14 && $urandom_range(0, 3) != 0) wd[2] = 1'b0;
            cyc(($urandom_range(0, 499) != 0), btn, re, we, addr, wd, "random");
        end
        idle(2, btn);

        @(posedge clk);
        #2;
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/user_io_ctrl.md
# user_io_ctrl

Memory-mapped controller for the board's user I/O (push-buttons, switches, LEDs) plus a free-running cycle counter, sitting on the Riscv151 I/O bus beside the UART. It converts debounced button presses into queued events, buffers them in a small FIFO so software polling cannot miss presses, synchronizes the switches, and holds the LED register. The CPU memory stage decodes the I/O region and drives this block with a word offset.

## Interface
Parameters:
- BTN_WIDTH, 3, number of clean_buttons inputs
- SW_WIDTH, 2, number of switch inputs
- LED_WIDTH, 6, LED output width
- FIFO_DEPTH, 8, button-event FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  CPU clock; all logic on posedge
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- clean_buttons  in  BTN_WIDTH  debounced, clk-synchronous buttons
- switches  in  SW_WIDTH  asynchronous switch inputs
- leds  out  LED_WIDTH  LED register
- io_addr  in  5  byte offset within the user-I/O window (word-aligned)
- io_re  in  1  read strobe
- io_we  in  1  write strobe
- io_wdata  in  32  write data
- io_rdata  out  32  registered read data

## Operation
Register map (offset: access, content):
- 0x00 STATUS, R: bit0 fifo_empty, bit1 fifo_full, bit2 overflow (sticky), others 0
- 0x04 BTN_DATA, R+pop: oldest event, bits [BTN_WIDTH-1:0]; read while empty returns 0 and does not move pointers
- 0x08 SWITCH, R: 2-flop synchronized switches, zero-extended
- 0x0C LED, R/W: write loads io_wdata[LED_WIDTH-1:0]; read returns it
- 0x10 CYCLES, R: 32-bit free-running counter, wraps 0xFFFF_FFFF→0
- 0x14 CTRL, W: bit0 clear CYCLES, bit1 clear overflow, bit2 flush FIFO; reads 0
- Unmapped offsets: reads 0, writes ignored.

Event generation:
- btn_prev registered each cycle; rise = clean_buttons & ~btn_prev.
- rise ≠ 0 → push rise vector (all buttons rising in the same cycle form one entry).
- Push while full and no pop: event dropped, overflow set.
- Push and pop same cycle: both take effect; when full, pop frees the slot and the push is accepted (count unchanged, no overflow); when empty, pop returns 0 and push lands.
- Flush and push same cycle: flush wins, event discarded, overflow unchanged.
- Clear-CYCLES same cycle as increment: counter becomes 0.
- io_re and io_we in the same cycle: both honoured independently.

## Timing
- Reset (rst=0 at posedge): leds=0, io_rdata=0, FIFO empty, overflow=0, CYCLES=0, switch sync flops=0; btn_prev loads clean_buttons so buttons held through reset produce no event.
- Reset mid-operation discards FIFO contents and LED value on that edge.
- Read latency 1: io_rdata valid the cycle after io_re, held until the next io_re; pop occurs on the io_re edge.
- Write takes effect on the io_we edge; LED read-back in the next cycle sees the new value.
- Press→FIFO: the entry is visible in STATUS on a read issued one cycle after the rising clean_buttons edge.
- SWITCH reflects the pin after 2 clk edges.
- CYCLES increments every cycle from the first edge after reset release; a CYCLES read returns the value before that edge's increment.

## Structure
- Shared package user_io_pkg: register offsets (STATUS, BTN_DATA, SWITCH, LED, CYCLES, CTRL), STATUS/CTRL bit indices.
- Sub-module user_io_fifo: synchronous FIFO, width BTN_WIDTH, depth FIFO_DEPTH, ptr+1-bit full/empty, push/pop/flush, same-cycle push/pop rules above.
- Top level: edge detect, switch synchronizer, LED register, counter, address decode, registered read mux.

## Test plan
- Reset with buttons=3'b010 held, release → STATUS reads 0x1 (empty), no event; LED=0, CYCLES small and incrementing.
- Rise button0, then buttons 1 and 2 together → STATUS 0x0; BTN_DATA reads 0x1, then 0x6, then 0x0 with STATUS 0x1.
- Nine distinct presses without reads → STATUS 0x6 (full+overflow); eight pops return the first eight events in order; CTRL write 0x2 → STATUS 0x1.
- Full FIFO, press coincident with BTN_DATA pop → oldest returned, new event queued last, overflow stays 0.
- Write LED 0xFFFF_FFEA → leds=6'b101010, read-back 0x2A; switches=2'b11 → SWITCH reads 0x3 after ≥3 cycles.
- CTRL write 0x1 → next CYCLES read ≤ 2; CTRL 0x4 with three queued events → STATUS 0x1.
